// File: rtl/counter_nbit_sync.sv
// Parametrised synchronous up/down counter with modulus, wrap/saturate mode,
// parallel load, clock-enable prescaler, registered terminal-count pulse and sticky overflow.
module counter_nbit_sync #(
  parameter int     WIDTH    = 4,
  parameter longint MODULUS  = 16,
  parameter bit     SATURATE = 1'b0,
  parameter int     PRESCALE = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             UP,
  input  logic             LD,
  input  logic [WIDTH-1:0] D,
  input  logic             CLR_OVF,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             OVF
);

  localparam int               PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
  localparam logic [PW-1:0]    PRE_MAX = PW'(PRESCALE - 1);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_next;
  logic [PW-1:0]    pre;
  logic [PW-1:0]    pre_next;
  logic             tc;
  logic             tc_next;
  logic             ovf;
  logic             ovf_next;

  logic [WIDTH-1:0] d_clamped;
  logic             at_max;
  logic             at_min;
  logic             step;

  // A load value outside the count range is pinned to the top of the range.
  assign d_clamped = ({1'b0, D} >= MOD_EXT) ? MAX_Q : D;
  assign at_max    = (q == MAX_Q);
  assign at_min    = (q == '0);
  assign step      = EN && (pre == PRE_MAX);

  always_comb begin
    q_next   = q;
    pre_next = pre;
    tc_next  = 1'b0;
    ovf_next = ovf & ~CLR_OVF;

    if (LD) begin
      q_next   = d_clamped;
      pre_next = '0;
    end else if (EN) begin
      if (!step) begin
        pre_next = pre + PW'(1);
      end else begin
        pre_next = '0;
        if (UP) begin
          if (at_max) begin
            q_next   = SATURATE ? q : '0;
            tc_next  = 1'b1;
            ovf_next = 1'b1;
          end else begin
            q_next = q + WIDTH'(1);
          end
        end else begin
          if (at_min) begin
            q_next   = SATURATE ? q : MAX_Q;
            tc_next  = 1'b1;
            ovf_next = 1'b1;
          end else begin
            q_next = q - WIDTH'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      q   <= '0;
      pre <= '0;
      tc  <= 1'b0;
      ovf <= 1'b0;
    end else begin
      q   <= q_next;
      pre <= pre_next;
      tc  <= tc_next;
      ovf <= ovf_next;
    end
  end

  assign Q   = q;
  assign TC  = tc;
  assign OVF = ovf;

endmodule

// File: tb/tb_counter_nbit_sync.sv
// Directed bench for counter_nbit_sync: four parameterisations share one input
// bus; each scenario starts from reset and checks only the instance it targets.
module tb_counter_nbit_sync;

  logic       clk;
  logic       rst;
  logic       en;
  logic       up;
  logic       ld;
  logic [3:0] d;
  logic       clr_ovf;

  logic [3:0] q_def,   q_wrap,   q_sat,   q_pre;
  logic       tc_def,  tc_wrap,  tc_sat,  tc_pre;
  logic       ovf_def, ovf_wrap, ovf_sat, ovf_pre;

  int n_checks = 0;
  int n_errors = 0;

  counter_nbit_sync #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0), .PRESCALE(1)) u_def (
    .CLK(clk), .RST(rst), .EN(en), .UP(up), .LD(ld), .D(d), .CLR_OVF(clr_ovf),
    .Q(q_def), .TC(tc_def), .OVF(ovf_def)
  );

  counter_nbit_sync #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0), .PRESCALE(1)) u_wrap (
    .CLK(clk), .RST(rst), .EN(en), .UP(up), .LD(ld), .D(d), .CLR_OVF(clr_ovf),
    .Q(q_wrap), .TC(tc_wrap), .OVF(ovf_wrap)
  );

  counter_nbit_sync #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1), .PRESCALE(1)) u_sat (
    .CLK(clk), .RST(rst), .EN(en), .UP(up), .LD(ld), .D(d), .CLR_OVF(clr_ovf),
    .Q(q_sat), .TC(tc_sat), .OVF(ovf_sat)
  );

  counter_nbit_sync #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0), .PRESCALE(3)) u_pre (
    .CLK(clk), .RST(rst), .EN(en), .UP(up), .LD(ld), .D(d), .CLR_OVF(clr_ovf),
    .Q(q_pre), .TC(tc_pre), .OVF(ovf_pre)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // prescale stimulus: en per cycle and expected q_pre after that edge
  logic       pre_en [11];
  logic [3:0] pre_exp[11];

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b1; ld = 1'b0; d = '0; clr_ovf = 1'b0;
    pre_en  = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1};
    pre_exp = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd2, 4'd3};

    tick();
    tick();
    rst = 1'b0;

    // reset state of every instance
    check("rst_q_def",    32'(q_def),    32'd0);
    check("rst_tc_def",   32'(tc_def),   32'd0);
    check("rst_ovf_def",  32'(ovf_def),  32'd0);
    check("rst_q_wrap",   32'(q_wrap),   32'd0);
    check("rst_q_sat",    32'(q_sat),    32'd0);
    check("rst_q_pre",    32'(q_pre),    32'd0);
    check("rst_ovf_pre",  32'(ovf_pre),  32'd0);

    // reset mid-count wins over load and enable
    en = 1'b1; up = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    check("midcnt_q", 32'(q_def), 32'd9);
    rst = 1'b1; ld = 1'b1; d = 4'd5;
    tick();
    rst = 1'b0; ld = 1'b0; en = 1'b0;
    check("midrst_q",   32'(q_def),   32'd0);
    check("midrst_tc",  32'(tc_def),  32'd0);
    check("midrst_ovf", 32'(ovf_def), 32'd0);

    // wrap up through MODULUS=10
    en = 1'b1; up = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      check("wrap_q",  32'(q_wrap),  32'(i));
      check("wrap_tc", 32'(tc_wrap), 32'd0);
    end
    check("wrap_ovf_pre", 32'(ovf_wrap), 32'd0);
    tick();
    check("wrap_q0",   32'(q_wrap),   32'd0);
    check("wrap_tc1",  32'(tc_wrap),  32'd1);
    check("wrap_ovf1", 32'(ovf_wrap), 32'd1);
    tick();
    check("wrap_q1",       32'(q_wrap),   32'd1);
    check("wrap_tc_pulse", 32'(tc_wrap),  32'd0);
    check("wrap_ovf_hold", 32'(ovf_wrap), 32'd1);

    // load leaves OVF alone; clear collides with a terminal event
    en = 1'b0; ld = 1'b1; d = 4'd9;
    tick();
    ld = 1'b0;
    check("ld_q9",      32'(q_wrap),   32'd9);
    check("ld_ovf_kept", 32'(ovf_wrap), 32'd1);
    en = 1'b1; clr_ovf = 1'b1;
    tick();
    check("coll_q",   32'(q_wrap),   32'd0);
    check("coll_tc",  32'(tc_wrap),  32'd1);
    check("coll_ovf", 32'(ovf_wrap), 32'd1);
    en = 1'b0;
    tick();
    clr_ovf = 1'b0;
    check("clr_ovf", 32'(ovf_wrap), 32'd0);
    check("clr_tc",  32'(tc_wrap),  32'd0);
    check("clr_q",   32'(q_wrap),   32'd0);

    // load clamp has priority over enable
    ld = 1'b1; en = 1'b1; d = 4'd15;
    tick();
    ld = 1'b0;
    check("clamp_q",  32'(q_wrap),  32'd9);
    check("clamp_tc", 32'(tc_wrap), 32'd0);
    tick();
    en = 1'b0;
    check("clamp_wrap_q",  32'(q_wrap),  32'd0);
    check("clamp_wrap_tc", 32'(tc_wrap), 32'd1);

    // saturate down from 1
    do_reset();
    ld = 1'b1; d = 4'd1;
    tick();
    ld = 1'b0;
    check("sat_ld_q", 32'(q_sat), 32'd1);
    en = 1'b1; up = 1'b0;
    tick();
    check("sat_q_a",   32'(q_sat),   32'd0);
    check("sat_tc_a",  32'(tc_sat),  32'd0);
    check("sat_ovf_a", 32'(ovf_sat), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("sat_q_hold", 32'(q_sat),   32'd0);
      check("sat_tc",     32'(tc_sat),  32'd1);
      check("sat_ovf",    32'(ovf_sat), 32'd1);
    end
    en = 1'b0;
    tick();
    check("sat_tc_off",   32'(tc_sat),  32'd0);
    check("sat_ovf_kept", 32'(ovf_sat), 32'd1);

    // saturate up at the top
    ld = 1'b1; d = 4'd8;
    tick();
    ld = 1'b0; en = 1'b1; up = 1'b1;
    tick();
    check("satup_q9",  32'(q_sat),  32'd9);
    check("satup_tc0", 32'(tc_sat), 32'd0);
    tick();
    en = 1'b0;
    check("satup_hold", 32'(q_sat),  32'd9);
    check("satup_tc1",  32'(tc_sat), 32'd1);

    // prescale by 3 with a two-cycle enable gap
    do_reset();
    up = 1'b1;
    for (int i = 0; i < 11; i++) begin
      en = pre_en[i];
      tick();
      check("pre_q",  32'(q_pre),  32'(pre_exp[i]));
      check("pre_tc", 32'(tc_pre), 32'd0);
    end
    // direction change mid-prescale applies at the next step
    en = 1'b1;
    tick();
    up = 1'b0;
    tick();
    check("pre_dir_hold", 32'(q_pre), 32'd3);
    tick();
    en = 1'b0;
    check("pre_dir_step", 32'(q_pre), 32'd2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
